// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture sequencer.
//   cap_state_t     - capture FSM state encoding
//   ENTRIES_DFLT    - default sample RAM depth
//   LOG2_DFLT       - default RAM address width
//   DEC_W           - width of the decimation strobe counter
//   dec_mask()      - 2^d - 1 at DEC_W bits, the terminal count for decimator d
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TRIG = 2'd2,
    DONE = 2'd3
  } cap_state_t;

  localparam int ENTRIES_DFLT = 384;
  localparam int LOG2_DFLT    = 9;
  localparam int DEC_W        = 16;

  function automatic logic [DEC_W-1:0] dec_mask(input logic [3:0] d);
    logic [DEC_W:0] one_hot;
    one_hot = (DEC_W+1)'(1) << d;
    return DEC_W'(one_hot - (DEC_W+1)'(1));
  endfunction

endpackage

// File: rtl/capture_ctrl_smpl_decimator.sv
// smpl_decimator: passes 1 of every 2^decimator sample strobes.
//   clk, rst_n  - system clock, async active-low reset
//   wrt_smpl    - raw sample strobe
//   decimator   - log2 of the decimation ratio
//   enable      - strobes are counted only while enabled
//   clr         - synchronous counter clear (capture start)
//   keep        - combinational: this strobe qualifies for a RAM write
module smpl_decimator
  import capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrt_smpl,
  input  logic [3:0] decimator,
  input  logic       enable,
  input  logic       clr,
  output logic       keep
);

  logic [DEC_W-1:0] dec_cnt;
  logic             tc_hit;

  assign tc_hit = (dec_cnt == dec_mask(decimator));
  assign keep   = wrt_smpl & enable & tc_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (clr) begin
      dec_cnt <= '0;
    end else if (wrt_smpl && enable) begin
      dec_cnt <= tc_hit ? '0 : dec_cnt + DEC_W'(1);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer for the logic-analyzer core.
//   clk, rst_n    - system clock, async active-low reset
//   wrt_smpl      - new channel samples valid this cycle
//   run           - capture enabled (level)
//   decimator     - keep 1 of every 2^decimator strobes
//   trig_pos      - number of post-trigger samples to store (< ENTRIES)
//   triggered     - trigger match, honoured only while armed
//   clr_cap_done  - acknowledge completion, return to IDLE
//   we, waddr     - sample RAM write enable / address (next address to write)
//   armed         - enough pre-trigger samples stored
//   capture_done  - capture complete, RAM frozen
//   rd_start      - oldest stored sample address, valid while capture_done
//
// state | meaning
// IDLE  | no writes, waiting for run
// RUN   | pre-trigger fill, circular
// TRIG  | post-trigger fill until trig_pos samples written
// DONE  | RAM frozen, capture_done until clr_cap_done
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DFLT,
  parameter int LOG2    = LOG2_DFLT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt_smpl,
  input  logic            run,
  input  logic [3:0]      decimator,
  input  logic [LOG2-1:0] trig_pos,
  input  logic            triggered,
  input  logic            clr_cap_done,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic            armed,
  output logic            capture_done,
  output logic [LOG2-1:0] rd_start
);

  localparam logic [LOG2:0]   ENT_W = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2-1:0] LAST  = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] ONE   = LOG2'(1);

  cap_state_t      state, state_nxt;
  logic            keep, dec_en, start, trig_hit, post_trig, write, arm_hit;
  logic [LOG2-1:0] waddr_nxt, trig_cnt;
  logic [LOG2:0]   smpl_cnt;

  assign dec_en   = (state == RUN) || (state == TRIG);
  assign start    = (state == IDLE) && run;
  assign trig_hit = armed && triggered;
  assign arm_hit  = (smpl_cnt + {1'b0, trig_pos}) >= ENT_W;

  smpl_decimator u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt_smpl  (wrt_smpl),
    .decimator (decimator),
    .enable    (dec_en),
    .clr       (start),
    .keep      (keep)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (run) state_nxt = RUN;
      RUN: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (trig_hit) begin
          // a strobe coincident with the trigger is post-trigger sample 1
          if (trig_pos == '0)                 state_nxt = DONE;
          else if (keep && (trig_pos == ONE)) state_nxt = DONE;
          else                                state_nxt = TRIG;
        end
      end
      TRIG: begin
        if (!run)                                        state_nxt = IDLE;
        else if (keep && ((trig_cnt + ONE) == trig_pos)) state_nxt = DONE;
      end
      DONE: if (clr_cap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes are dropped on abort and when a zero-length post-trigger
  // window closes the capture in the trigger cycle itself.
  always_comb begin
    post_trig = (state == TRIG) || ((state == RUN) && trig_hit);
    write     = keep && run && !((state == RUN) && trig_hit && (trig_pos == '0));
    waddr_nxt = waddr;
    if (start)   waddr_nxt = '0;
    else if (we) waddr_nxt = (waddr == LAST) ? '0 : waddr + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      we           <= 1'b0;
      waddr        <= '0;
      smpl_cnt     <= '0;
      trig_cnt     <= '0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
      rd_start     <= '0;
    end else begin
      state <= state_nxt;
      we    <= write;
      waddr <= waddr_nxt;

      if (start)
        smpl_cnt <= '0;
      else if (write && (state == RUN) && (smpl_cnt != ENT_W))
        smpl_cnt <= smpl_cnt + (LOG2+1)'(1);

      if (start)                   trig_cnt <= '0;
      else if (write && post_trig) trig_cnt <= trig_cnt + ONE;

      if (state_nxt == IDLE)                 armed <= 1'b0;
      else if ((state == RUN) && arm_hit)    armed <= 1'b1;

      // The final write lands in the first DONE cycle, so the oldest-sample
      // address and the done flag both settle one clock into DONE.
      capture_done <= (state == DONE) && !clr_cap_done;
      if (state == DONE) rd_start <= waddr_nxt;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;
  import capture_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, wrt_smpl, run, triggered, clr_cap_done;
  logic [3:0] decimator;
  logic [8:0] trig_pos;
  logic       we, armed, capture_done;
  logic [8:0] waddr, rd_start;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int base;

  always #5 clk = ~clk;

  capture_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrt_smpl     (wrt_smpl),
    .run          (run),
    .decimator    (decimator),
    .trig_pos     (trig_pos),
    .triggered    (triggered),
    .clr_cap_done (clr_cap_done),
    .we           (we),
    .waddr        (waddr),
    .armed        (armed),
    .capture_done (capture_done),
    .rd_start     (rd_start)
  );

  always @(negedge clk) if (we === 1'b1) wr_total <= wr_total + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      wrt_smpl = 1'b1;
      tick();
      wrt_smpl = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic trig_pulse();
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    tick();
  endtask

  task automatic finish_capture();
    run = 1'b0;
    clr_cap_done = 1'b1;
    tick();
    clr_cap_done = 1'b0;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wrt_smpl = 1'b0; run = 1'b0; triggered = 1'b0;
    clr_cap_done = 1'b0; decimator = 4'd0; trig_pos = 9'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // idle: strobes ignored
    base = wr_total;
    for (int i = 0; i < 20; i++) begin
      wrt_smpl = ~wrt_smpl;
      tick();
    end
    wrt_smpl = 1'b0;
    tick();
    chk("idle_writes", wr_total - base, 0);
    chk("idle_waddr", waddr, 0);
    chk("idle_armed", armed, 0);
    chk("idle_done", capture_done, 0);

    // decimator 0, trig_pos 100
    decimator = 4'd0; trig_pos = 9'd100; run = 1'b1;
    tick();
    base = wr_total;
    pulse(283, 4);
    chk("t2_armed_283", armed, 0);
    pulse(1, 4);
    chk("t2_armed_284", armed, 1);
    pulse(16, 4);
    trig_pulse();
    pulse(99, 4);
    chk("t2_done_early", capture_done, 0);
    pulse(1, 4);
    chk("t2_done", capture_done, 1);
    chk("t2_writes", wr_total - base, 400);
    chk("t2_waddr", waddr, 16);
    chk("t2_rd_start", rd_start, 16);
    pulse(5, 4);
    chk("t2_no_we_after_done", wr_total - base, 400);
    chk("t2_done_hold", capture_done, 1);
    finish_capture();
    chk("t2_clr_done", capture_done, 0);
    chk("t2_clr_armed", armed, 0);

    // decimator 3, trig_pos 0
    decimator = 4'd3; trig_pos = 9'd0; run = 1'b1;
    tick();
    base = wr_total;
    pulse(7, 3);
    chk("t3_dec_7", wr_total - base, 0);
    pulse(1, 3);
    chk("t3_dec_8", wr_total - base, 1);
    pulse(3064, 3);
    chk("t3_writes", wr_total - base, 384);
    chk("t3_armed", armed, 1);
    chk("t3_waddr", waddr, 0);
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    tick();
    chk("t3_done", capture_done, 1);
    chk("t3_rd_start", rd_start, 0);
    chk("t3_writes_after", wr_total - base, 384);
    finish_capture();

    // trig_pos 383
    decimator = 4'd0; trig_pos = 9'd383; run = 1'b1;
    tick();
    base = wr_total;
    pulse(1, 4);
    chk("t4_armed_first", armed, 1);
    pulse(4, 4);
    trig_pulse();
    pulse(382, 4);
    chk("t4_done_early", capture_done, 0);
    pulse(1, 4);
    chk("t4_done", capture_done, 1);
    chk("t4_writes", wr_total - base, 388);
    chk("t4_rd_start", rd_start, 4);
    finish_capture();

    // trigger before armed is ignored
    trig_pos = 9'd10; run = 1'b1;
    tick();
    base = wr_total;
    pulse(50, 4);
    trig_pulse();
    pulse(323, 4);
    chk("t5_armed_373", armed, 0);
    chk("t5_not_done", capture_done, 0);
    pulse(1, 4);
    chk("t5_armed_374", armed, 1);
    trig_pulse();
    pulse(9, 4);
    chk("t5_done_early", capture_done, 0);
    pulse(1, 4);
    chk("t5_done", capture_done, 1);
    chk("t5_rd_start", rd_start, 0);
    finish_capture();

    // abort in TRIG, then restart
    trig_pos = 9'd50; run = 1'b1;
    tick();
    base = wr_total;
    pulse(340, 4);
    trig_pulse();
    pulse(5, 4);
    run = 1'b0;
    tick();
    chk("t6_abort_done", capture_done, 0);
    chk("t6_abort_armed", armed, 0);
    pulse(3, 4);
    chk("t6_idle_writes", wr_total - base, 345);
    trig_pos = 9'd383; run = 1'b1;
    tick();
    chk("t6_restart_waddr", waddr, 0);
    pulse(2, 4);
    chk("t6_restart_waddr2", waddr, 2);
    chk("t6_restart_armed", armed, 1);

    // async reset mid-RUN
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_we", we, 0);
    chk("t7_rst_waddr", waddr, 0);
    chk("t7_rst_armed", armed, 0);
    chk("t7_rst_done", capture_done, 0);
    chk("t7_rst_rd_start", rd_start, 0);
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
